// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA stream receiver with timing lock, pixel republish and probe capture
//
// Samples HS/VS/RGB on the pixel clock, rebuilds the transmitter's horizontal
// and vertical counters, checks line/frame geometry and declares lock after
// LOCK_FRAMES consecutive clean frames. While locked, active-area pixels are
// republished with coordinates, and the colour at a per-frame latched probe
// coordinate is captured.
//
// Ports:
//   i_clk25MHz, i_reset_n          pixel clock, synchronous active-low reset
//   i_vga_hs, i_vga_vs             active-high sync inputs
//   i_vga_r/g/b                    8-bit colour inputs
//   i_probe_x, i_probe_y           probe coordinate (active-area relative)
//   o_pix_de, o_pix_x/y, o_pix_r/g/b  republished active pixel (zeroed when !de)
//   o_probe_valid, o_probe_r/g/b   probe update pulse and last captured colour
//   o_line_len, o_frame_lines      last measured line length / frame height
//   o_locked, o_sync_err           lock status, geometry violation pulse
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 526,
  parameter int H_ACT_START = 145,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 36,
  parameter int V_ACT_END   = 514,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_clk25MHz,
  input  logic       i_reset_n,
  input  logic       i_vga_hs,
  input  logic       i_vga_vs,
  input  logic [7:0] i_vga_r,
  input  logic [7:0] i_vga_g,
  input  logic [7:0] i_vga_b,
  input  logic [9:0] i_probe_x,
  input  logic [9:0] i_probe_y,
  output logic       o_pix_de,
  output logic [9:0] o_pix_x,
  output logic [9:0] o_pix_y,
  output logic [7:0] o_pix_r,
  output logic [7:0] o_pix_g,
  output logic [7:0] o_pix_b,
  output logic       o_probe_valid,
  output logic [7:0] o_probe_r,
  output logic [7:0] o_probe_g,
  output logic [7:0] o_probe_b,
  output logic [9:0] o_line_len,
  output logic [9:0] o_frame_lines,
  output logic       o_locked,
  output logic       o_sync_err
);

  typedef enum logic [1:0] {ST_UNLOCKED = 2'd0, ST_CHECK = 2'd1, ST_LOCKED = 2'd2} state_t;

  localparam logic [10:0] LP_H_TOTAL = 11'(H_TOTAL);
  localparam logic [10:0] LP_V_TOTAL = 11'(V_TOTAL);
  localparam logic [9:0]  LP_HAS     = 10'(H_ACT_START);
  localparam logic [9:0]  LP_HAE     = 10'(H_ACT_END);
  localparam logic [9:0]  LP_VAS     = 10'(V_ACT_START);
  localparam logic [9:0]  LP_VAE     = 10'(V_ACT_END);
  localparam logic [3:0]  LP_LOCK    = 4'(LOCK_FRAMES);

  logic       r_s1_hs, r_s1_vs, r_s2_hs, r_s2_vs;
  logic [7:0] r_s1_r, r_s1_g, r_s1_b, r_s2_r, r_s2_g, r_s2_b;
  logic [9:0] r_s1_px, r_s1_py, r_probe_x, r_probe_y;
  logic [9:0] r_hcnt, r_vcnt, r_line_len, r_frame_lines;
  state_t     r_state, w_state_nx;
  logic [3:0] r_good_cnt, w_good_nx, w_good_p1;
  logic       r_locked, r_sync_err;
  logic       r_pix_de, r_probe_valid;
  logic [9:0] r_pix_x, r_pix_y;
  logic [7:0] r_pix_r, r_pix_g, r_pix_b, r_probe_r, r_probe_g, r_probe_b;

  logic        w_hs_edge, w_vs_edge, w_viol, w_check;
  logic [10:0] w_hcnt_p1, w_vcnt_p1;
  logic        w_in_act, w_de_nx, w_probe_hit;
  logic [9:0]  w_px_nx, w_py_nx;

  assign w_hs_edge = r_s1_hs & ~r_s2_hs;
  assign w_vs_edge = r_s1_vs & ~r_s2_vs;
  assign w_hcnt_p1 = {1'b0, r_hcnt} + 11'd1;
  assign w_vcnt_p1 = {1'b0, r_vcnt} + 11'd1;
  assign w_good_p1 = r_good_cnt + 4'd1;
  assign w_check   = (r_state != ST_UNLOCKED);

  // Saturation is flagged on the step into 1023 so a stuck HS yields one pulse.
  assign w_viol = (w_vs_edge & ~w_hs_edge)
                | (w_hs_edge & (w_hcnt_p1 != LP_H_TOTAL))
                | (w_hs_edge & w_vs_edge & (w_vcnt_p1 != LP_V_TOTAL))
                | (~w_hs_edge & (r_hcnt == 10'd1022));

  // r_hcnt/r_vcnt describe the sample currently held in s2.
  assign w_in_act    = (r_hcnt >= LP_HAS) && (r_hcnt <= LP_HAE) &&
                       (r_vcnt >= LP_VAS) && (r_vcnt <= LP_VAE);
  assign w_de_nx     = r_locked & w_in_act;
  assign w_px_nx     = r_hcnt - LP_HAS;
  assign w_py_nx     = r_vcnt - LP_VAS;
  assign w_probe_hit = w_de_nx && (w_px_nx == r_probe_x) && (w_py_nx == r_probe_y);

  always_ff @(posedge i_clk25MHz) begin
    if (!i_reset_n) begin
      r_state    <= ST_UNLOCKED;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_good_cnt <= w_good_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good_cnt;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_vs_edge) begin
          w_state_nx = ST_CHECK;
          w_good_nx  = '0;
        end
      end
      ST_CHECK: begin
        if (w_viol) begin
          w_state_nx = ST_UNLOCKED;
        end else if (w_vs_edge) begin
          w_good_nx = w_good_p1;
          if (w_good_p1 == LP_LOCK) w_state_nx = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_viol) w_state_nx = ST_UNLOCKED;
      end
      default: w_state_nx = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge i_clk25MHz) begin
    if (!i_reset_n) begin
      r_s1_hs <= 1'b0; r_s1_vs <= 1'b0; r_s2_hs <= 1'b0; r_s2_vs <= 1'b0;
      r_s1_r <= '0; r_s1_g <= '0; r_s1_b <= '0;
      r_s2_r <= '0; r_s2_g <= '0; r_s2_b <= '0;
      r_s1_px <= '0; r_s1_py <= '0; r_probe_x <= '0; r_probe_y <= '0;
      r_hcnt <= '0; r_vcnt <= '0; r_line_len <= '0; r_frame_lines <= '0;
      r_locked <= 1'b0; r_sync_err <= 1'b0;
      r_pix_de <= 1'b0; r_pix_x <= '0; r_pix_y <= '0;
      r_pix_r <= '0; r_pix_g <= '0; r_pix_b <= '0;
      r_probe_valid <= 1'b0; r_probe_r <= '0; r_probe_g <= '0; r_probe_b <= '0;
    end else begin
      r_s1_hs <= i_vga_hs; r_s1_vs <= i_vga_vs;
      r_s1_r <= i_vga_r; r_s1_g <= i_vga_g; r_s1_b <= i_vga_b;
      r_s1_px <= i_probe_x; r_s1_py <= i_probe_y;
      r_s2_hs <= r_s1_hs; r_s2_vs <= r_s1_vs;
      r_s2_r <= r_s1_r; r_s2_g <= r_s1_g; r_s2_b <= r_s1_b;

      // Probe is frozen for the whole frame to avoid mid-frame tearing.
      if (w_vs_edge) begin
        r_probe_x <= r_s1_px;
        r_probe_y <= r_s1_py;
      end

      if (w_hs_edge) begin
        r_line_len <= w_hcnt_p1[9:0];
        r_hcnt     <= '0;
        if (w_vs_edge) begin
          r_frame_lines <= w_vcnt_p1[9:0];
          r_vcnt        <= '0;
        end else if (r_vcnt != 10'h3FF) begin
          r_vcnt <= r_vcnt + 10'd1;
        end
      end else if (r_hcnt != 10'h3FF) begin
        r_hcnt <= r_hcnt + 10'd1;
      end

      r_locked   <= (r_state == ST_LOCKED);
      r_sync_err <= w_check & w_viol;

      r_pix_de <= w_de_nx;
      r_pix_x  <= w_de_nx ? w_px_nx : 10'd0;
      r_pix_y  <= w_de_nx ? w_py_nx : 10'd0;
      r_pix_r  <= w_de_nx ? r_s2_r  : 8'd0;
      r_pix_g  <= w_de_nx ? r_s2_g  : 8'd0;
      r_pix_b  <= w_de_nx ? r_s2_b  : 8'd0;

      r_probe_valid <= w_probe_hit;
      if (w_probe_hit) begin
        r_probe_r <= r_s2_r;
        r_probe_g <= r_s2_g;
        r_probe_b <= r_s2_b;
      end
    end
  end

  assign o_pix_de      = r_pix_de;
  assign o_pix_x       = r_pix_x;
  assign o_pix_y       = r_pix_y;
  assign o_pix_r       = r_pix_r;
  assign o_pix_g       = r_pix_g;
  assign o_pix_b       = r_pix_b;
  assign o_probe_valid = r_probe_valid;
  assign o_probe_r     = r_probe_r;
  assign o_probe_g     = r_probe_g;
  assign o_probe_b     = r_probe_b;
  assign o_line_len    = r_line_len;
  assign o_frame_lines = r_frame_lines;
  assign o_locked      = r_locked;
  assign o_sync_err    = r_sync_err;

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - scoreboard testbench for vga_capture on a reduced 40x24 raster
module tb_vga_capture;

  localparam int HT  = 40;
  localparam int VT  = 24;
  localparam int HAS = 10;
  localparam int HAE = 33;
  localparam int VAS = 4;
  localparam int VAE = 19;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hs, vs;
  logic [7:0] r, g, b;
  logic [9:0] px, py;
  logic       o_pix_de, o_probe_valid, o_locked, o_sync_err;
  logic [9:0] o_pix_x, o_pix_y, o_line_len, o_frame_lines;
  logic [7:0] o_pix_r, o_pix_g, o_pix_b, o_probe_r, o_probe_g, o_probe_b;

  vga_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_ACT_START(VAS), .V_ACT_END(VAE), .LOCK_FRAMES(2)
  ) dut (
    .i_clk25MHz(clk), .i_reset_n(reset_n), .i_vga_hs(hs), .i_vga_vs(vs),
    .i_vga_r(r), .i_vga_g(g), .i_vga_b(b), .i_probe_x(px), .i_probe_y(py),
    .o_pix_de(o_pix_de), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y),
    .o_pix_r(o_pix_r), .o_pix_g(o_pix_g), .o_pix_b(o_pix_b),
    .o_probe_valid(o_probe_valid), .o_probe_r(o_probe_r), .o_probe_g(o_probe_g),
    .o_probe_b(o_probe_b), .o_line_len(o_line_len), .o_frame_lines(o_frame_lines),
    .o_locked(o_locked), .o_sync_err(o_sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } exp_t;

  exp_t pq[$];
  exp_t prq[$];
  int   seq[$];

  int         n_total = 0;
  int         n_bad   = 0;
  bit         mon_en  = 1'b0;
  bit         exp_lock = 1'b0;
  logic [9:0] lp_x = '0, lp_y = '0;
  int         chg_line = -1;
  logic [9:0] chg_x = '0, chg_y = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {o_pix_de, o_pix_x, o_pix_y, o_pix_r, o_pix_g, o_pix_b,
               o_probe_valid, o_probe_r, o_probe_g, o_probe_b,
               o_line_len, o_frame_lines, o_locked, o_sync_err}, '0);
  endtask

  function automatic logic [23:0] color(input int x, input int y);
    if (x == 15 && y == 10) return 24'hFF0000;
    if (x == 15 && y == 11) return 24'h00FF00;
    return 24'h112233;
  endfunction

  // mode: 0 normal, 1 line 8 one clock short, 2 HS stuck low from line 3, 3 reset at line 12 x=36
  task automatic send_line(input int y, input int len, input int mode);
    logic [23:0] c;
    exp_t        e;
    for (int x = 0; x < len; x++) begin
      @(posedge clk);
      #1;
      if (mode == 3 && y == 12 && x == 37) begin
        chk_zero("reset_mid_frame");
        reset_n = 1'b1;
      end
      if (x == 0 && y == chg_line) begin
        px = chg_x;
        py = chg_y;
      end
      c  = color(x, y);
      hs = (x < 4);
      vs = (y < 2);
      {r, g, b} = c;
      if (x == 0 && y == 0) begin
        lp_x = px;
        lp_y = py;
      end
      if (mode == 1 && y == 9 && x == 0) begin
        exp_lock = 1'b0;
        seq.push_back(cyc + 2);
      end
      if (mode == 1 && y == 9 && x == 5) begin
        chk("short_line_len", o_line_len, 10'd39);
        chk("short_line_unlock", o_locked, 1'b0);
      end
      if (mode == 2 && y == 3 && x == 0) begin
        exp_lock = 1'b0;
        seq.push_back(cyc + 1025);
      end
      if (mode == 3 && y == 12 && x == 36) begin
        chk("locked_before_reset", o_locked, 1'b1);
        reset_n  = 1'b0;
        exp_lock = 1'b0;
      end
      if (exp_lock && x >= HAS && x <= HAE && y >= VAS && y <= VAE) begin
        e.cyc = cyc + 3;
        e.x   = 10'(x - HAS);
        e.y   = 10'(y - VAS);
        e.rgb = c;
        pq.push_back(e);
        if (e.x == lp_x && e.y == lp_y) prq.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input bit lk, input int mode);
    exp_lock = lk;
    for (int y = 0; y < VT; y++) begin
      if (mode == 2 && y == 3) begin
        chk("locked_before_hold", o_locked, 1'b1);
        send_line(3, 1100, mode);
        return;
      end
      send_line(y, (mode == 1 && y == 8) ? HT - 1 : HT, mode);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        chk("pixel", {o_pix_de, o_pix_x, o_pix_y, o_pix_r, o_pix_g, o_pix_b},
                     {1'b1, pq[0].x, pq[0].y, pq[0].rgb});
        void'(pq.pop_front());
      end else begin
        chk("pix_idle", {o_pix_de, o_pix_x, o_pix_y, o_pix_r, o_pix_g, o_pix_b}, '0);
      end
      if (prq.size() > 0 && prq[0].cyc == cyc) begin
        chk("probe", {o_probe_valid, o_probe_r, o_probe_g, o_probe_b}, {1'b1, prq[0].rgb});
        void'(prq.pop_front());
      end else begin
        chk("probe_idle", o_probe_valid, 1'b0);
      end
      if (seq.size() > 0 && seq[0] == cyc) begin
        chk("sync_err", o_sync_err, 1'b1);
        void'(seq.pop_front());
      end else begin
        chk("sync_idle", o_sync_err, 1'b0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    hs = 1'b0; vs = 1'b0; r = '0; g = '0; b = '0; px = '0; py = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    mon_en  = 1'b1;
    reset_n = 1'b1;

    send_frame(1'b0, 0);
    send_frame(1'b0, 0);
    chk("unlocked_before_3rd_vs", o_locked, 1'b0);
    chg_line = 20; chg_x = 10'd5; chg_y = 10'd7;
    send_frame(1'b1, 0);
    chk("locked_after_3rd_vs", o_locked, 1'b1);
    chk("line_len", o_line_len, 10'd40);
    chk("frame_lines", o_frame_lines, 10'd24);

    chg_line = 5; chg_x = 10'd0; chg_y = 10'd0;
    send_frame(1'b1, 0);
    chk("probe_green", {o_probe_r, o_probe_g, o_probe_b}, 24'h00FF00);
    chg_line = 15; chg_x = 10'd30; chg_y = 10'd0;
    send_frame(1'b1, 0);
    chk("probe_next_frame", {o_probe_r, o_probe_g, o_probe_b}, 24'h112233);
    chg_line = -1;
    send_frame(1'b1, 0);
    chk("probe_out_of_range_hold", {o_probe_r, o_probe_g, o_probe_b}, 24'h112233);

    send_frame(1'b1, 1);
    send_frame(1'b0, 0);
    send_frame(1'b0, 0);
    chk("relock_pending", o_locked, 1'b0);
    send_frame(1'b1, 2);
    chk("hold_unlocked", {o_locked, o_pix_de}, 2'b00);

    send_frame(1'b0, 0);
    send_frame(1'b0, 0);
    send_frame(1'b1, 3);
    send_frame(1'b0, 0);
    chg_line = 10; chg_x = 10'd5; chg_y = 10'd6;
    send_frame(1'b0, 0);
    chg_line = -1;
    send_frame(1'b1, 0);
    chk("relocked_after_reset", o_locked, 1'b1);
    chk("line_len_final", o_line_len, 10'd40);
    chk("frame_lines_final", o_frame_lines, 10'd24);
    chk("probe_red", {o_probe_r, o_probe_g, o_probe_b}, 24'hFF0000);

    repeat (5) @(posedge clk);
    #1;
    chk("pixel_queue_drained", pq.size(), 0);
    chk("probe_queue_drained", prq.size(), 0);
    chk("sync_queue_drained", seq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
